// File: rtl/tt_harness_pkg.sv
// Shared constants for the vector harness: FSM encoding and latency limits.
package tt_harness_pkg;

    localparam int LAT_MAX = 7;
    localparam int DRAIN_W = $clog2(LAT_MAX + 1);

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/tt_vector_harness_if.sv
// Vector-memory configuration bus; the bench (master) loads stimulus/expected pairs.
interface tt_vector_harness_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) ();
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [DATA_W-1:0] cfg_stim;
    logic [DATA_W-1:0] cfg_exp;

    modport master (output cfg_we, output cfg_addr, output cfg_stim, output cfg_exp);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_stim, input  cfg_exp);
endinterface

// File: rtl/tt_harness_delay.sv
// Fixed-depth delay line with clearable stages; depth 0 is a plain wire.
module tt_harness_delay #(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] out_data
);

    generate
        if (D == 0) begin : g_pass
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ rst;
            assign out_data = in_data;
        end else begin : g_pipe
            logic [W-1:0] stage_q [D];
            logic [W-1:0] stage_d [D];

            // Shift one stage per clock.
            always_comb begin
                stage_d[0] = in_data;
                for (int i = 1; i < D; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Stage registers; reset drops any in-flight entries.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign out_data = stage_q[D-1];
        end
    endgenerate

endmodule

// File: rtl/tt_vector_harness.sv
// Replays stored stimulus vectors into a DUT and scores its delayed responses
// against stored expected values.
module tt_vector_harness
    import tt_harness_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    parameter int  LAT    = 1,
    parameter int  CNT_W  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    tt_vector_harness_if.slave  cfg,
    input  logic [AW-1:0]       cfg_last,
    input  logic                start,
    input  logic                loop_mode,
    input  logic                stop,
    output logic [DATA_W-1:0]   stim_out,
    output logic                stim_valid,
    input  logic [DATA_W-1:0]   dut_resp,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_count,
    output logic [AW-1:0]       first_err_idx
);

    localparam int                 DLW   = 1 + AW + DATA_W;
    localparam logic [DRAIN_W-1:0] LAT_L = DRAIN_W'(LAT);
    localparam logic [CNT_W-1:0]   SAT   = {CNT_W{1'b1}};

    logic [DATA_W-1:0] stim_mem [DEPTH];
    logic [DATA_W-1:0] exp_mem  [DEPTH];

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                loop_q, loop_d;
    logic                stop_req_q, stop_req_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                stim_valid_q, stim_valid_d;
    logic [DATA_W-1:0]   stim_out_q, stim_out_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [AW-1:0]       first_q, first_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                issue_s;
    logic                accept_s;
    logic                mismatch_s;
    logic [AW-1:0]       nxt_idx_s;
    logic [DLW-1:0]      dly_in_s, dly_out_s;
    logic                dly_valid_s;
    logic [AW-1:0]       dly_idx_s;
    logic [DATA_W-1:0]   dly_exp_s;

    // Vector memory has no reset so loaded vectors survive rst; locked while busy.
    always_ff @(posedge clk) begin
        if (cfg.cfg_we && !busy_q) begin
            stim_mem[cfg.cfg_addr] <= cfg.cfg_stim;
            exp_mem[cfg.cfg_addr]  <= cfg.cfg_exp;
        end
    end

    assign dly_in_s = {stim_valid_q, idx_q, exp_q};

    tt_harness_delay #(.W(DLW), .D(LAT)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .in_data  (dly_in_s),
        .out_data (dly_out_s)
    );

    assign {dly_valid_s, dly_idx_s, dly_exp_s} = dly_out_s;

    // Run sequencing, vector issue and response scoring.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        loop_d       = loop_q;
        stop_req_d   = stop_req_q;
        drain_d      = drain_q;
        stim_valid_d = 1'b0;
        stim_out_d   = '0;
        exp_d        = '0;
        err_d        = err_q;
        first_d      = first_q;
        issue_s      = 1'b0;
        accept_s     = 1'b0;
        nxt_idx_s    = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    issue_s    = 1'b1;
                    state_d    = ST_RUN;
                    idx_d      = '0;
                    loop_d     = loop_mode;
                    stop_req_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                stop_req_d = stop_req_q | stop;
                // A loop run only stops once the pass in flight reaches cfg_last.
                if ((idx_q == cfg_last) && (!loop_q || stop_req_q || stop)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    issue_s   = 1'b1;
                    nxt_idx_s = (idx_q == cfg_last) ? '0 : idx_q + {{(AW-1){1'b0}}, 1'b1};
                    idx_d     = nxt_idx_s;
                end
            end
            ST_DRAIN: begin
                if (drain_q == LAT_L) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + {{(DRAIN_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_s) begin
            stim_valid_d = 1'b1;
            stim_out_d   = stim_mem[nxt_idx_s];
            exp_d        = exp_mem[nxt_idx_s];
        end else begin
            stim_valid_d = 1'b0;
        end

        mismatch_s = dly_valid_s && (dut_resp != dly_exp_s);
        if (accept_s) begin
            err_d   = '0;
            first_d = '0;
        end else if (mismatch_s) begin
            // err_q only reads zero before the first mismatch of a run, since it saturates.
            if (err_q == '0) begin
                first_d = dly_idx_s;
            end else begin
                first_d = first_q;
            end
            if (err_q != SAT) begin
                err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_d = err_q;
            end
        end else begin
            err_d = err_q;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            loop_q       <= 1'b0;
            stop_req_q   <= 1'b0;
            drain_q      <= '0;
            stim_valid_q <= 1'b0;
            stim_out_q   <= '0;
            exp_q        <= '0;
            err_q        <= '0;
            first_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            loop_q       <= loop_d;
            stop_req_q   <= stop_req_d;
            drain_q      <= drain_d;
            stim_valid_q <= stim_valid_d;
            stim_out_q   <= stim_out_d;
            exp_q        <= exp_d;
            err_q        <= err_d;
            first_q      <= first_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign stim_out      = stim_out_q;
    assign stim_valid    = stim_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: doc/tt_vector_harness.md
TT_VECTOR_HARNESS -- requirements
Module: tt_vector_harness

Interface
REQ-001 SHALL have parameter DATA_W, 8, width of stimulus and response vectors.
REQ-002 SHALL have parameter DEPTH, 16, number of vector slots, a power of two from 2 to 256; AW = log2(DEPTH).
REQ-003 SHALL have parameter LAT, 1, DUT response latency in cycles, from 0 to 7.
REQ-004 SHALL have parameter CNT_W, 8, width of the error counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port cfg_we, input, 1, vector-memory write strobe.
REQ-008 SHALL have port cfg_addr, input, AW, vector slot written by cfg_we.
REQ-009 SHALL have port cfg_stim, input, DATA_W, stimulus value to store.
REQ-010 SHALL have port cfg_exp, input, DATA_W, expected response to store.
REQ-011 SHALL have port cfg_last, input, AW, index of the final vector in a pass.
REQ-012 SHALL have port start, input, 1, single-cycle run request.
REQ-013 SHALL have port loop_mode, input, 1, sampled at start; 1 selects continuous replay.
REQ-014 SHALL have port stop, input, 1, ends a loop-mode run.
REQ-015 SHALL have port stim_out, output, DATA_W, stimulus driven to the DUT, for example ui_in.
REQ-016 SHALL have port stim_valid, output, 1, high while stim_out carries a vector.
REQ-017 SHALL have port dut_resp, input, DATA_W, DUT response, for example uo_out.
REQ-018 SHALL have outputs busy, done and pass, each 1 bit, giving run status.
REQ-019 SHALL have output err_count, CNT_W, number of mismatches.
REQ-020 SHALL have output first_err_idx, AW, vector index of the first mismatch.

Function
REQ-021 SHALL use the state machine IDLE, RUN, DRAIN, DONE, with the following transitions:
- IDLE to RUN on start.
- RUN to DRAIN after vector cfg_last is issued when loop_mode=0, or on the first vector boundary with stop=1 when loop_mode=1.
- DRAIN to DONE after LAT+1 cycles.
- DONE to RUN on start.
REQ-022 SHALL ignore cfg_we while busy=1; the memory content is unchanged.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL drive the vectors as follows:
- Cycle after start is accepted: stim_out=stim[0] and stim_valid=1.
- Each following RUN cycle: the index increments by 1.
REQ-025 SHALL wrap the index from cfg_last to 0 in loop mode; there is no bubble cycle at the wrap.
REQ-026 SHALL, in DRAIN, IDLE and DONE, hold stim_valid=0 and stim_out=0.
REQ-027 SHALL pipe stim_valid, the index and exp[index] through a LAT-stage delay line; on each delayed-valid cycle it compares dut_resp with the delayed expected value.
REQ-028 SHALL, on a mismatch, increment err_count, saturating at 2^CNT_W-1.
REQ-029 SHALL capture first_err_idx on the first mismatch only.
REQ-030 SHALL clear err_count and first_err_idx when start is accepted.
REQ-031 SHALL drive the status outputs as follows:
- busy=1 in RUN and DRAIN.
- done=1 in DONE.
- pass=done AND (err_count==0).
REQ-032 SHALL, with LAT=0, compare combinationally against dut_resp in the same cycle as stim_out.
REQ-033 SHALL, when cfg_last=0, issue exactly one vector per pass.

Reset
REQ-034 SHALL, while rst=1, asynchronously force the following, independent of clk:
- state=IDLE.
- stim_out=0 and stim_valid=0.
- busy=0, done=0 and pass=0.
- err_count=0 and first_err_idx=0.
- all delay-line valid bits=0.
REQ-035 SHALL NOT clear vector-memory contents on reset.
REQ-036 SHALL, when reset occurs mid-run, report no compare for in-flight vectors and return to IDLE.

Structure
REQ-037 SHALL take the state encoding type and the LAT maximum constant from shared package tt_harness_pkg.
REQ-038 SHALL implement the delay line as sub-module tt_harness_delay, parametrised in width and depth, with a pass-through mode at depth 0.

Verification
REQ-039 SHALL cover this scenario: DATA_W=8, DEPTH=16, LAT=1, cfg_last=3, a DUT modelled as a registered identity, and exp=stim -> 4 stim_valid cycles, then done=1, pass=1 and err_count=0.
REQ-040 SHALL cover this scenario: same setup with exp[2] corrupted to 0xFF while stim[2]=0x12 -> err_count=1, first_err_idx=2 and pass=0.
REQ-041 SHALL cover this scenario: loop_mode=1, cfg_last=1 and stop raised after 5 vectors -> the index sequence is 0,1,0,1,0,1 and the run ends at the vector boundary.
REQ-042 SHALL cover this scenario: an inverting DUT on 8 vectors with CNT_W=2 -> err_count saturates at 3 and first_err_idx=0.
REQ-043 SHALL cover this scenario: rst pulsed mid-RUN at index 2 -> all outputs are 0 asynchronously, state is IDLE, a restart begins at index 0, and the memory is intact.
REQ-044 SHALL cover this scenario: cfg_we and start asserted while busy -> there is no memory change and no restart.
